// File: rtl/j1_io_pkg.sv
// j1_io_pkg: shared constants and types for the J1 data-port I/O responder
//   - IO_PREFIX   : mem_addr[13:12] value selecting the top 4K-word I/O window
//   - OFF_*       : register offsets (mem_addr[2:0]) inside the window
//   - ST_*        : bit positions inside the STATUS register
//   - tx_state_t  : UART transmit serializer state encoding
package j1_io_pkg;

   localparam logic [1:0] IO_PREFIX = 2'b11;

   localparam logic [2:0] OFF_TXDATA   = 3'd0;
   localparam logic [2:0] OFF_STATUS   = 3'd1;
   localparam logic [2:0] OFF_RXDATA   = 3'd2;
   localparam logic [2:0] OFF_GPIO_OUT = 3'd3;
   localparam logic [2:0] OFF_GPIO_IN  = 3'd4;
   localparam logic [2:0] OFF_TICKS    = 3'd5;

   localparam int ST_TX_FULL    = 0;
   localparam int ST_TX_EMPTY   = 1;
   localparam int ST_RX_VALID   = 2;
   localparam int ST_RX_OVERRUN = 3;
   localparam int ST_TX_DROP    = 4;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   function automatic logic in_io_window(input logic [13:0] addr);
      return addr[13:12] == IO_PREFIX;
   endfunction

endpackage

// File: rtl/j1_uart_tx.sv
// j1_uart_tx: buffered 8N1 UART transmitter (byte FIFO + serializer + baud counter)
//   clk, reset : clock, synchronous active-high reset
//   i_push     : enqueue request for i_byte
//   i_byte     : byte to enqueue
//   o_full     : FIFO holds 2**TXFIFO_LOG2 bytes
//   o_empty    : FIFO empty and serializer idle
//   o_drop     : push this cycle is being discarded (FIFO full, no same-cycle pop)
//   o_level    : FIFO occupancy
//   o_txd      : registered serial output, idle high
module j1_uart_tx
   import j1_io_pkg::*;
#(
   parameter int CLK_DIV     = 217,
   parameter int TXFIFO_LOG2 = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_push,
   input  logic [7:0]           i_byte,
   output logic                 o_full,
   output logic                 o_empty,
   output logic                 o_drop,
   output logic [TXFIFO_LOG2:0] o_level,
   output logic                 o_txd
);

   localparam int DEPTH = 1 << TXFIFO_LOG2;
   localparam int BW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

   logic [7:0]             r_mem [DEPTH];
   logic [TXFIFO_LOG2:0]   r_wp, r_rp;
   tx_state_t              r_state, w_state_nxt;
   logic [BW-1:0]          r_baud, w_baud_nxt;
   logic [2:0]             r_bit, w_bit_nxt;
   logic [7:0]             r_shift, w_shift_nxt;
   logic                   r_txd, w_txd_nxt;
   logic                   w_pop, w_push_ok, w_baud_end, w_fifo_empty;

   // Pointers carry one extra bit so full and empty are distinguishable.
   assign o_level      = r_wp - r_rp;
   assign w_fifo_empty = (r_wp == r_rp);
   assign o_full       = (o_level == (TXFIFO_LOG2 + 1)'(DEPTH));
   assign o_empty      = w_fifo_empty & (r_state == TX_IDLE);
   assign w_baud_end   = (r_baud == BAUD_LAST);
   // A pop in the same cycle frees the slot the push needs.
   assign w_push_ok    = i_push & (~o_full | w_pop);
   assign o_drop       = i_push & ~w_push_ok;
   assign o_txd        = r_txd;

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = w_baud_end ? '0 : r_baud + 1'b1;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
      case (r_state)
         TX_IDLE: begin
            w_baud_nxt = '0;
            w_pop      = ~w_fifo_empty;
         end
         TX_START: if (w_baud_end) begin
            w_state_nxt = TX_DATA;
            w_bit_nxt   = '0;
         end
         TX_DATA: if (w_baud_end) begin
            w_shift_nxt = r_shift >> 1;
            w_bit_nxt   = r_bit + 1'b1;
            if (r_bit == 3'd7) w_state_nxt = TX_STOP;
         end
         TX_STOP: if (w_baud_end) begin
            // Chaining straight into START keeps back-to-back frames gapless.
            w_pop       = ~w_fifo_empty;
            w_state_nxt = TX_IDLE;
         end
         default: w_state_nxt = TX_IDLE;
      endcase
      if (w_pop) begin
         w_state_nxt = TX_START;
         w_shift_nxt = r_mem[r_rp[TXFIFO_LOG2-1:0]];
         w_baud_nxt  = '0;
      end
      // Output is registered from next-state so the line never glitches.
      w_txd_nxt = (w_state_nxt == TX_START) ? 1'b0 :
                  (w_state_nxt == TX_DATA)  ? w_shift_nxt[0] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_state <= TX_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_txd   <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_txd   <= w_txd_nxt;
         if (w_push_ok) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wp[TXFIFO_LOG2-1:0]] <= i_byte;
   end

endmodule

// File: rtl/j1_io_responder.sv
// j1_io_responder: J1 data-port I/O responder for the top 4K-word window
//   Optional build macro: J1IO_TICK_EN (adds the 16-bit TICKS counter at offset 5)
//   clk, reset   : clock, synchronous active-high reset
//   mem_addr     : word address from the core
//   mem_wr       : write strobe from the core
//   dout         : write data from the core
//   io_sel       : address falls inside the I/O window
//   io_din       : combinational read data for mem_addr
//   uart_txd     : serial transmit line, idle high
//   rx_byte      : byte from the external UART receiver
//   rx_strobe    : one-cycle valid for rx_byte
//   gpio_out     : GPIO output register
//   gpio_in      : asynchronous GPIO inputs
module j1_io_responder
   import j1_io_pkg::*;
#(
   parameter int CLK_DIV     = 217,
   parameter int TXFIFO_LOG2 = 4,
   parameter int GPIO_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [13:0]       mem_addr,
   input  logic              mem_wr,
   input  logic [15:0]       dout,
   output logic              io_sel,
   output logic [15:0]       io_din,
   output logic              uart_txd,
   input  logic [7:0]        rx_byte,
   input  logic              rx_strobe,
   output logic [GPIO_W-1:0] gpio_out,
   input  logic [GPIO_W-1:0] gpio_in
);

   logic [2:0]             w_off;
   logic                   w_we, w_ack;
   logic                   w_tx_full, w_tx_empty, w_tx_drop;
   logic [TXFIFO_LOG2:0]   w_tx_level;
   logic [15:0]            w_rdata;
   logic                   w_unused;
   logic [GPIO_W-1:0]      r_gpio_out, r_gpio_sync1, r_gpio_sync2;
   logic [7:0]             r_rx_hold;
   logic                   r_rx_valid, r_rx_over, r_tx_drop;

   assign io_sel   = in_io_window(mem_addr);
   assign w_off    = mem_addr[2:0];
   assign w_we     = mem_wr & io_sel;
   assign w_ack    = w_we & (w_off == OFF_RXDATA);
   assign gpio_out = r_gpio_out;
   assign w_unused = ^{mem_addr[11:3], dout};

   j1_uart_tx #(
      .CLK_DIV     (CLK_DIV),
      .TXFIFO_LOG2 (TXFIFO_LOG2)
   ) u_tx (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_we & (w_off == OFF_TXDATA)),
      .i_byte  (dout[7:0]),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_drop  (w_tx_drop),
      .o_level (w_tx_level),
      .o_txd   (uart_txd)
   );

`ifdef J1IO_TICK_EN
   logic [15:0] r_ticks;
   // A clearing write takes priority over the free-running increment.
   always_ff @(posedge clk) begin
      if (reset) r_ticks <= '0;
      else r_ticks <= (w_we && w_off == OFF_TICKS) ? '0 : r_ticks + 1'b1;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_gpio_out   <= '0;
         r_gpio_sync1 <= '0;
         r_gpio_sync2 <= '0;
         r_rx_hold    <= '0;
         r_rx_valid   <= 1'b0;
         r_rx_over    <= 1'b0;
         r_tx_drop    <= 1'b0;
      end else begin
         r_gpio_sync1 <= gpio_in;
         r_gpio_sync2 <= r_gpio_sync1;
         if (w_we && w_off == OFF_GPIO_OUT) r_gpio_out <= dout[GPIO_W-1:0];
         if (w_tx_drop) r_tx_drop <= 1'b1;
         else if (w_we && w_off == OFF_STATUS) r_tx_drop <= 1'b0;
         // Ack is applied before a same-cycle capture, so capture+ack leaves a clean valid byte.
         r_rx_valid <= rx_strobe | (r_rx_valid & ~w_ack);
         r_rx_over  <= ~w_ack & (r_rx_over | (rx_strobe & r_rx_valid));
         if (rx_strobe) r_rx_hold <= rx_byte;
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_off)
         OFF_TXDATA:   w_rdata = 16'(w_tx_level);
         OFF_STATUS: begin
            w_rdata[ST_TX_FULL]    = w_tx_full;
            w_rdata[ST_TX_EMPTY]   = w_tx_empty;
            w_rdata[ST_RX_VALID]   = r_rx_valid;
            w_rdata[ST_RX_OVERRUN] = r_rx_over;
            w_rdata[ST_TX_DROP]    = r_tx_drop;
         end
         OFF_RXDATA:   w_rdata = {8'h00, r_rx_hold};
         OFF_GPIO_OUT: w_rdata = 16'(r_gpio_out);
         OFF_GPIO_IN:  w_rdata = 16'(r_gpio_sync2);
`ifdef J1IO_TICK_EN
         OFF_TICKS:    w_rdata = r_ticks;
`endif
         default:      w_rdata = '0;
      endcase
   end

   assign io_din = io_sel ? w_rdata : '0;

endmodule

// File: tb/tb_j1_io_responder.sv
// tb_j1_io_responder: randomized and directed self-checking bench for j1_io_responder
module tb_j1_io_responder;

   localparam int CLK_DIV = 4;
   localparam int LOG2    = 4;
   localparam int DEPTH   = 16;
   localparam int GW      = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [13:0]   mem_addr = '0;
   logic          mem_wr = 1'b0;
   logic [15:0]   dout = '0;
   logic          io_sel;
   logic [15:0]   io_din;
   logic          uart_txd;
   logic [7:0]    rx_byte = '0;
   logic          rx_strobe = 1'b0;
   logic [GW-1:0] gpio_out;
   logic [GW-1:0] gpio_in = '0;

   int n_tests = 0;
   int n_fail  = 0;
   bit found;
   int seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

   always #5 clk = ~clk;

   j1_io_responder #(
      .CLK_DIV     (CLK_DIV),
      .TXFIFO_LOG2 (LOG2),
      .GPIO_W      (GW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_addr  (mem_addr),
      .mem_wr    (mem_wr),
      .dout      (dout),
      .io_sel    (io_sel),
      .io_din    (io_din),
      .uart_txd  (uart_txd),
      .rx_byte   (rx_byte),
      .rx_strobe (rx_strobe),
      .gpio_out  (gpio_out),
      .gpio_in   (gpio_in)
   );

   // Behavioural model: a byte queue plus a "frame in flight" with cycles remaining.
   logic [7:0]  q [$];
   bit          m_busy;
   int          m_rem;
   logic [7:0]  m_cur, m_gpio, m_g1, m_g2, m_hold;
   bit          m_valid, m_over, m_drop;
   logic [15:0] m_ticks;

   task automatic model_step();
      bit we, pop, full, ack;
      logic [2:0] off;
      if (reset) begin
         q.delete();
         m_busy = 0; m_rem = 0; m_cur = 0;
         m_gpio = 0; m_g1 = 0; m_g2 = 0; m_hold = 0;
         m_valid = 0; m_over = 0; m_drop = 0; m_ticks = 0;
         return;
      end
      we   = mem_wr && (mem_addr[13:12] == 2'b11);
      off  = mem_addr[2:0];
      ack  = we && off == 3'd2;
      full = q.size() == DEPTH;
      pop  = (!m_busy || m_rem == 1) && q.size() > 0;
      if (pop) begin
         m_cur  = q.pop_front();
         m_busy = 1;
         m_rem  = 10 * CLK_DIV;
      end else if (m_busy) begin
         if (m_rem == 1) m_busy = 0;
         else m_rem--;
      end
      if (we && off == 3'd0) begin
         if (!full || pop) q.push_back(dout[7:0]);
         else m_drop = 1;
      end
      if (we && off == 3'd1) m_drop = 0;
      if (rx_strobe) begin
         m_over  = (m_valid && !ack) ? 1'b1 : (ack ? 1'b0 : m_over);
         m_valid = 1;
         m_hold  = rx_byte;
      end else if (ack) begin
         m_valid = 0;
         m_over  = 0;
      end
      m_g2 = m_g1;
      m_g1 = gpio_in;
      if (we && off == 3'd3) m_gpio = dout[7:0];
      m_ticks = (we && off == 3'd5) ? 16'h0000 : m_ticks + 16'h0001;
   endtask

   function automatic logic m_txd();
      int idx;
      if (!m_busy) return 1'b1;
      idx = (10 * CLK_DIV - m_rem) / CLK_DIV;
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return m_cur[3'(idx - 1)];
   endfunction

   function automatic logic [15:0] m_read(input logic [13:0] a);
      if (a[13:12] != 2'b11) return 16'h0000;
      case (a[2:0])
         3'd0: return 16'(q.size());
         3'd1: return {11'b0, m_drop, m_over, m_valid, (q.size() == 0 && !m_busy), (q.size() == DEPTH)};
         3'd2: return {8'h00, m_hold};
         3'd3: return {8'h00, m_gpio};
         3'd4: return {8'h00, m_g2};
`ifdef J1IO_TICK_EN
         3'd5: return m_ticks;
`endif
         default: return 16'h0000;
      endcase
   endfunction

   task automatic cmp(input string n, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (!reset) begin
         cmp("txd", 16'(uart_txd), 16'(m_txd()));
         cmp("io_sel", 16'(io_sel), 16'(mem_addr[13:12] == 2'b11));
         cmp("io_din", io_din, m_read(mem_addr));
         cmp("gpio_out", 16'(gpio_out), 16'(m_gpio));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] off, input logic [15:0] d);
      mem_addr = {2'b11, 9'd0, off};
      mem_wr   = 1'b1;
      dout     = d;
      step();
      mem_wr   = 1'b0;
   endtask

   task automatic rd_chk(input string n, input logic [2:0] off, input logic [15:0] exp);
      mem_addr = {2'b11, 9'd0, off};
      mem_wr   = 1'b0;
      #1;
      cmp(n, io_din, exp);
      step();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      cmp("reset_txd", 16'(uart_txd), 16'h0001);
      rd_chk("reset_ticks", 3'd5, 16'h0000);
      rd_chk("reset_status", 3'd1, 16'h0002);
      rd_chk("reset_gpio", 3'd3, 16'h0000);
      rd_chk("reset_level", 3'd0, 16'h0000);
      rd_chk("unmapped6", 3'd6, 16'h0000);

      wr(3'd0, 16'h00A5);
      found = 0;
      for (int i = 0; i < 3; i++) begin
         if (uart_txd == 1'b0) begin
            found = 1;
            break;
         end
         step();
      end
      cmp("a5_start_seen", 16'(found), 16'h0001);
      for (int c = 0; c < 40; c++) begin
         if (c % 4 == 1) cmp($sformatf("a5_bit%0d", c / 4), 16'(uart_txd), 16'(seq[c / 4]));
         step();
      end
      rd_chk("a5_done_status", 3'd1, 16'h0002);

      mem_addr = {2'b11, 9'd0, 3'd0};
      mem_wr   = 1'b1;
      for (int i = 0; i < 17; i++) begin
         dout = 16'(i + 16'h30);
         step();
      end
      mem_wr = 1'b0;
      rd_chk("burst_level", 3'd0, 16'h0010);
      rd_chk("burst_status", 3'd1, 16'h0001);
      wr(3'd0, 16'h0099);
      rd_chk("drop_status", 3'd1, 16'h0011);
      wr(3'd1, 16'h0000);
      rd_chk("drop_clear", 3'd1, 16'h0001);
      found = 0;
      mem_addr = {2'b11, 9'd0, 3'd1};
      for (int i = 0; i < 1000; i++) begin
         #1;
         if (io_din[1]) begin
            found = 1;
            break;
         end
         step();
      end
      cmp("drain_done", 16'(found), 16'h0001);
      step();

      rx_byte = 8'h3C; rx_strobe = 1'b1; step();
      rx_byte = 8'h7E; step();
      rx_strobe = 1'b0;
      rd_chk("rx_data", 3'd2, 16'h007E);
      rd_chk("rx_overrun_status", 3'd1, 16'h000E);
      wr(3'd2, 16'h1234);
      rd_chk("rx_ack_status", 3'd1, 16'h0002);
      rx_byte = 8'h22; rx_strobe = 1'b1; step();
      rx_byte = 8'h33; step();
      rx_byte = 8'h11;
      mem_addr = {2'b11, 9'd0, 3'd2};
      mem_wr = 1'b1;
      step();
      rx_strobe = 1'b0; mem_wr = 1'b0;
      rd_chk("rx_same_status", 3'd1, 16'h0006);
      rd_chk("rx_same_data", 3'd2, 16'h0011);

      wr(3'd3, 16'h00F0);
      cmp("gpio_pin", 16'(gpio_out), 16'h00F0);
      rd_chk("gpio_rd", 3'd3, 16'h00F0);
      gpio_in = 8'h5A;
      rd_chk("gpio_in_0clk", 3'd4, 16'h0000);
      rd_chk("gpio_in_1clk", 3'd4, 16'h0000);
      rd_chk("gpio_in_2clk", 3'd4, 16'h005A);

`ifdef J1IO_TICK_EN
      wr(3'd5, 16'h0000);
      rd_chk("ticks_clr", 3'd5, 16'h0000);
      rd_chk("ticks_one", 3'd5, 16'h0001);
      wr(3'd5, 16'hFFFF);
      repeat (65535) step();
      rd_chk("ticks_max", 3'd5, 16'hFFFF);
      rd_chk("ticks_wrap", 3'd5, 16'h0000);
`else
      wr(3'd5, 16'h0000);
      rd_chk("ticks_absent", 3'd5, 16'h0000);
      rd_chk("ticks_absent2", 3'd5, 16'h0000);
`endif

      wr(3'd0, 16'h005C);
      wr(3'd0, 16'h00C5);
      repeat (10) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      cmp("rst_txd", 16'(uart_txd), 16'h0001);
      rd_chk("rst_status", 3'd1, 16'h0002);
      rd_chk("rst_level", 3'd0, 16'h0000);
      rd_chk("rst_gpio", 3'd3, 16'h0000);

      mem_addr = 14'h0005;
      #1;
      cmp("outside_sel", 16'(io_sel), 16'h0000);
      step();

      for (int i = 0; i < 3000; i++) begin
         mem_addr  = ($urandom_range(0, 3) == 0) ? 14'($urandom) :
                     {2'b11, 9'($urandom), ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(0, 7))};
         mem_wr    = ($urandom_range(0, 3) == 0);
         dout      = 16'($urandom);
         rx_strobe = ($urandom_range(0, 7) == 0);
         rx_byte   = 8'($urandom);
         if ($urandom_range(0, 15) == 0) gpio_in = 8'($urandom);
         reset     = ($urandom_range(0, 999) == 0);
         step();
      end
      reset = 1'b0; mem_wr = 1'b0; rx_strobe = 1'b0;
      repeat (5) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
